// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register netlist built from library cells
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_MSB,
  input  logic             SI_LSB,
  output logic [WIDTH-1:0] Q,
  output logic             SO_MSB,
  output logic             SO_LSB,
  output logic             ZERO
);

  logic m0_n, m1_n, rst_n;
  logic sel_hold, sel_sr, sel_sl, sel_ld;

  // MODE decode shared by every bit: one-hot select of the four mux legs
  inv  u_inv_m0  (.a(MODE[0]), .y(m0_n));
  inv  u_inv_m1  (.a(MODE[1]), .y(m1_n));
  inv  u_inv_rst (.a(RST),     .y(rst_n));
  and2 u_sel_hold (.a(m1_n),    .b(m0_n),    .y(sel_hold));
  and2 u_sel_sr   (.a(m1_n),    .b(MODE[0]), .y(sel_sr));
  and2 u_sel_sl   (.a(MODE[1]), .b(m0_n),    .y(sel_sl));
  and2 u_sel_ld   (.a(MODE[1]), .b(MODE[0]), .y(sel_ld));

  logic [WIDTH-1:0] sr_src, sl_src;
  logic [WIDTH-1:0] t_hold, t_sr, t_sl, t_ld;
  logic [WIDTH-1:0] o_a, o_b, mux_out, d_gated;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // End bits take the serial inputs; shifted-out bits simply fall off
    if (i == WIDTH - 1) begin : g_sr_end
      assign sr_src[i] = SI_MSB;
    end else begin : g_sr_mid
      assign sr_src[i] = Q[i+1];
    end
    if (i == 0) begin : g_sl_end
      assign sl_src[i] = SI_LSB;
    end else begin : g_sl_mid
      assign sl_src[i] = Q[i-1];
    end

    and2 u_t_hold (.a(sel_hold), .b(Q[i]),      .y(t_hold[i]));
    and2 u_t_sr   (.a(sel_sr),   .b(sr_src[i]), .y(t_sr[i]));
    and2 u_t_sl   (.a(sel_sl),   .b(sl_src[i]), .y(t_sl[i]));
    and2 u_t_ld   (.a(sel_ld),   .b(D[i]),      .y(t_ld[i]));
    or2  u_o_a    (.a(t_hold[i]), .b(t_sr[i]),  .y(o_a[i]));
    or2  u_o_b    (.a(t_sl[i]),   .b(t_ld[i]),  .y(o_b[i]));
    or2  u_o_mux  (.a(o_a[i]),    .b(o_b[i]),   .y(mux_out[i]));

    // Reset gate sits right at the D pin so it overrides every mode
    and2 u_rst_gate (.a(mux_out[i]), .b(rst_n), .y(d_gated[i]));
    dff  u_ff       (.clk(CLK), .d(d_gated[i]), .q(Q[i]));
  end

  assign SO_MSB = Q[WIDTH-1];
  assign SO_LSB = Q[0];

  // OR chain over the low bits, closed by a NOR with the top bit
  logic [WIDTH-2:0] or_acc;
  assign or_acc[0] = Q[0];
  for (genvar i = 1; i <= WIDTH - 2; i++) begin : g_zero
    or2 u_or (.a(or_acc[i-1]), .b(Q[i]), .y(or_acc[i]));
  end
  nor2 u_zero (.a(or_acc[WIDTH-2]), .b(Q[WIDTH-1]), .y(ZERO));

endmodule

// Library cell: rising-edge D flip-flop, no reset
module dff (
  input  logic clk,
  input  logic d,
  output logic q
);
  // Capture D on the rising edge
  always_ff @(posedge clk) q <= d;
endmodule

// Library cell: inverter
module inv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// Library cell: 2-input AND
module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// Library cell: 2-input OR
module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// Library cell: 2-input NOR
module nor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a | b);
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] d;
  logic       si_msb, si_lsb;
  logic [7:0] q;
  logic       so_msb, so_lsb, zero;

  logic       rst4;
  logic [1:0] mode4;
  logic [3:0] d4;
  logic       si_lsb4;
  logic [3:0] q4;
  logic       so_msb4, so_lsb4, zero4;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8)) dut (
    .CLK(clk), .RST(rst), .MODE(mode), .D(d),
    .SI_MSB(si_msb), .SI_LSB(si_lsb),
    .Q(q), .SO_MSB(so_msb), .SO_LSB(so_lsb), .ZERO(zero)
  );

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst4), .MODE(mode4), .D(d4),
    .SI_MSB(so_lsb4), .SI_LSB(si_lsb4),
    .Q(q4), .SO_MSB(so_msb4), .SO_LSB(so_lsb4), .ZERO(zero4)
  );

  function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic r,
                                          input logic [1:0] md, input logic [7:0] dd,
                                          input logic sm, input logic sl);
    int v;
    v = int'(cur);
    if (r) return 8'h00;
    case (md)
      2'd0: v = v;
      2'd1: v = (v / 2) + (sm ? 128 : 0);
      2'd2: v = ((v * 2) % 256) + (sl ? 1 : 0);
      default: v = int'(dd);
    endcase
    return v[7:0];
  endfunction

  task automatic cycle(input logic r, input logic [1:0] md, input logic [7:0] dd,
                       input logic sm, input logic sl);
    rst = r; mode = md; d = dd; si_msb = sm; si_lsb = sl;
    @(posedge clk);
    #1;
    m = ref_next(m, r, md, dd, sm, sl);
  endtask

  task automatic test_reset;
    cycle(1'b1, 2'b11, 8'hA5, 1'b1, 1'b1);
    vectors++;
    if (q !== 8'h00) begin $display("FAIL reset_q got=%h exp=00", q); miscompares++; end
    vectors++;
    if (zero !== 1'b1) begin $display("FAIL reset_zero got=%b exp=1", zero); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'b11, 8'hFF, 1'b1, 1'b1);
      vectors++;
      if (q !== 8'h00) begin $display("FAIL reset_hold got=%h exp=00", q); miscompares++; end
    end
  endtask

  task automatic test_load_hold;
    cycle(1'b0, 2'b11, 8'h3C, 1'b0, 1'b0);
    vectors++;
    if (q !== 8'h3C || zero !== 1'b0) begin
      $display("FAIL load q=%h zero=%b exp=3c/0", q, zero); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'b00, 8'hFF, 1'b1, 1'b1);
      vectors++;
      if (q !== 8'h3C) begin $display("FAIL hold got=%h exp=3c", q); miscompares++; end
    end
  endtask

  task automatic test_shift_right;
    cycle(1'b0, 2'b11, 8'h81, 1'b0, 1'b0);
    cycle(1'b0, 2'b01, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (q !== 8'h40 || so_lsb !== 1'b0) begin
      $display("FAIL shr1 q=%h so_lsb=%b exp=40/0", q, so_lsb); miscompares++;
    end
    cycle(1'b0, 2'b01, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 2'b01, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (q !== 8'hD0) begin $display("FAIL shr3 got=%h exp=d0", q); miscompares++; end
  endtask

  task automatic test_shift_left;
    cycle(1'b0, 2'b11, 8'h81, 1'b0, 1'b0);
    cycle(1'b0, 2'b10, 8'h00, 1'b1, 1'b1);
    vectors++;
    if (q !== 8'h03 || so_msb !== 1'b0) begin
      $display("FAIL shl1 q=%h so_msb=%b exp=03/0", q, so_msb); miscompares++;
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'b10, 8'hFF, 1'b1, 1'b0);
    vectors++;
    if (q !== 8'h00 || zero !== 1'b1) begin
      $display("FAIL shl_discard q=%h zero=%b exp=00/1", q, zero); miscompares++;
    end
  endtask

  task automatic test_reset_priority;
    cycle(1'b0, 2'b11, 8'hF0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 8'hFF, 1'b1, 1'b1);
    vectors++;
    if (q !== 8'h00) begin $display("FAIL rst_prio got=%h exp=00", q); miscompares++; end
    cycle(1'b0, 2'b10, 8'hFF, 1'b0, 1'b1);
    vectors++;
    if (q !== 8'h01) begin $display("FAIL rst_release got=%h exp=01", q); miscompares++; end
  endtask

  task automatic test_rotate;
    logic [3:0] exp4;
    rst4 = 1'b0; mode4 = 2'b11; d4 = 4'b0001; si_lsb4 = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (q4 !== 4'b0001) begin $display("FAIL rot_load got=%b exp=0001", q4); miscompares++; end
    exp4 = 4'b0001;
    mode4 = 2'b01; d4 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp4 = (exp4 >> 1) | ((exp4 & 4'b0001) << 3);
      @(posedge clk); #1;
      vectors++;
      if (q4 !== exp4) begin $display("FAIL rot_step%0d got=%b exp=%b", i, q4, exp4); miscompares++; end
    end
    mode4 = 2'b00;
  endtask

  task automatic test_random;
    logic       r, sm, sl;
    logic [1:0] md;
    logic [7:0] dd;
    cycle(1'b1, 2'b00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      md = 2'($urandom_range(0, 3));
      dd = 8'($urandom);
      sm = 1'($urandom);
      sl = 1'($urandom);
      cycle(r, md, dd, sm, sl);
      vectors++;
      if (q !== m || so_msb !== m[7] || so_lsb !== m[0] || zero !== (m == 8'h00)) begin
        $display("FAIL random%0d q=%h so=%b%b zero=%b exp q=%h so=%b%b zero=%b",
                 i, q, so_msb, so_lsb, zero, m, m[7], m[0], (m == 8'h00));
        miscompares++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; d = 8'h00; si_msb = 1'b0; si_lsb = 1'b0;
    rst4 = 1'b1; mode4 = 2'b00; d4 = 4'h0; si_lsb4 = 1'b0;
    m = 8'h00;
    test_reset();
    rst4 = 1'b0;
    test_load_hold();
    test_shift_right();
    test_shift_left();
    test_reset_priority();
    test_rotate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register built structurally from the standard-cell library (`dff`, `inv`, `and2`, `or2`, `nor2`, and wider `and`/`or` gates as needed). It adds a synchronous active-high reset, hold, bidirectional serial shift and parallel load on top of the bare `dff` primitive. It is the first multi-bit sequential netlist in the cell set, and serves as a workload for the event-driven simulator and as a building block for counters and serial links.

## Interface
- WIDTH, 8, number of register bits; legal range 2..32.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous active-high reset; clears Q on the next rising CLK edge.
- MODE  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- SI_MSB  input  1  serial input entering bit WIDTH-1 on shift right.
- SI_LSB  input  1  serial input entering bit 0 on shift left.
- Q  output  WIDTH  register contents.
- SO_MSB  output  1  equals Q[WIDTH-1].
- SO_LSB  output  1  equals Q[0].
- ZERO  output  1  high when Q == 0 (combinational from Q).

## Operation
- One library `dff` per bit. The next-state logic in front of each D pin is a 4:1 mux built from `and2`/`or2`/`inv` (or wider AND/OR cells), decoded from MODE.
- Per-bit next state, in priority order:
  - RST = 1: 0. Reset dominates MODE, D and serial inputs.
  - MODE = 00: Q[i] (feedback hold).
  - MODE = 01: Q[i+1]; for bit WIDTH-1 it is SI_MSB. Whole-word result is Q <= {SI_MSB, Q[WIDTH-1:1]}.
  - MODE = 10: Q[i-1]; for bit 0 it is SI_LSB. Whole-word result is Q <= {Q[WIDTH-2:0], SI_LSB}.
  - MODE = 11: D[i].
- Reset gating is an `and2` of the mux output with inverted RST, placed directly in front of each `dff` D pin. There is no asynchronous path.
- SO_MSB and SO_LSB are wires from the end bits. ZERO is a NOR tree over Q.
- Wrap-around: bits shifted out at either end are discarded. There is no rotate mode. A rotate is obtained externally by tying SO_LSB to SI_MSB (or SO_MSB to SI_LSB).
- No behavioural or `always` constructs. The block is a pure cell-instance netlist, so the event-driven simulator evaluates it gate by gate.

## Timing
- Latency: Q reflects the selected operation one CLK rising edge after the inputs are applied. The `dff` master is transparent while CLK is low and the slave while CLK is high, which gives positive-edge behaviour.
- Setup: RST, MODE, D and SI_* must be stable for the full low phase of CLK and through the rising edge. Changes while CLK is high take effect at the next rising edge.
- Reset value: Q = 0, SO_MSB = 0, SO_LSB = 0, ZERO = 1, all valid after the first rising edge with RST = 1.
- Before the first reset edge, Q is unknown (the `dff` cell has no reset). ZERO and SO_* follow Q and are also unknown.
- Reset mid-operation: RST asserted during any MODE clears Q at that edge. The shift or load that would have occurred is lost.
- Reset release: the first edge with RST = 0 performs the operation selected by MODE at that edge.
- Output glitches: ZERO and SO_* may glitch in simulation while the slave latches settle after the edge. They are sampled only at the next edge.

## Test plan
- Reset: Q initially X; RST = 1, MODE = 11, D = 8'hA5 for one edge -> Q = 8'h00, ZERO = 1. Hold RST = 1 for 3 edges -> Q stays 8'h00.
- Parallel load then hold: RST = 0, MODE = 11, D = 8'h3C, one edge -> Q = 8'h3C, ZERO = 0. MODE = 00, D = 8'hFF for 4 edges -> Q stays 8'h3C.
- Shift right: Q = 8'h81, MODE = 01, SI_MSB = 0, one edge -> Q = 8'h40, SO_LSB = 0. SI_MSB = 1 for 2 more edges -> Q = 8'hD0.
- Shift left with discard: Q = 8'h81, MODE = 10, SI_LSB = 1, one edge -> Q = 8'h03, SO_MSB = 0. Then 8 edges with SI_LSB = 0 -> Q = 8'h00, ZERO = 1.
- Reset priority mid-shift: Q = 8'hF0, MODE = 10, RST = 1 for one edge -> Q = 8'h00 (no shift). Next edge with RST = 0, SI_LSB = 1 -> Q = 8'h01.
- External rotate at WIDTH = 4: SO_LSB tied to SI_MSB, Q = 4'b0001, MODE = 01 -> Q sequence 1000, 0100, 0010, 0001 over 4 edges.
